// File: rtl/bpf_regs_pkg.sv
// Shared register-file types and constants.
// Imported by the register file, its load-tag FIFO and the downstream select mux.
package bpf_regs_pkg;

    localparam int DATA_W   = 8;
    localparam int NREGS    = 4;
    localparam int ADDR_W   = 2;
    localparam int LD_DEPTH = 2;

    typedef logic [DATA_W-1:0] reg_t;
    typedef logic [ADDR_W-1:0] regaddr_t;

endpackage : bpf_regs_pkg

// File: rtl/ld_tag_fifo.sv
// In-order FIFO of destination tags for loads that are still in flight.
// Every slot's valid bit and tag are exported so the parent can OR-reduce
// them into a per-register pending vector without waiting on a pop.
module ld_tag_fifo
    import bpf_regs_pkg::*;
#(
    parameter int DEPTH = LD_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  regaddr_t             push_tag,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output regaddr_t             head_tag,
    output logic [DEPTH-1:0]     entry_valid,
    output regaddr_t             entry_tag [DEPTH]
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    regaddr_t           tag_q   [DEPTH];
    regaddr_t           tag_d   [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               push_ok;
    logic               pop_ok;

    // Pointer advance that wraps at DEPTH, so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Flags come only from registered count so no input reaches them combinationally.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
    end

    // Next-state for slots, pointers and occupancy; a pop frees the head slot
    // before a push claims the tail slot so both may happen in one cycle.
    always_comb begin
        tag_d    = tag_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_next(rd_ptr_q);
        end
        if (push_ok) begin
            tag_d[wr_ptr_q]   = push_tag;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ptr_next(wr_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards every outstanding tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Expose slot contents for the pending OR-reduction and the oldest tag for retirement.
    always_comb begin
        head_tag    = tag_q[rd_ptr_q];
        entry_valid = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_tag[i] = tag_q[i];
        end
    end

endmodule : ld_tag_fifo

// File: rtl/regfile_sb.sv
// Four-entry register file with a load scoreboard.
// ALU results write in one cycle; memory loads are tracked by destination tag
// until their data returns, and ALU writes to a register with a load still in
// flight are dropped and flagged so the older load cannot be overtaken.
module regfile_sb #(
    parameter int DATA_W   = bpf_regs_pkg::DATA_W,
    parameter int NREGS    = bpf_regs_pkg::NREGS,
    parameter int LD_DEPTH = bpf_regs_pkg::LD_DEPTH
) (
    input  logic              iCLK,
    input  logic              inRST,
    input  logic              iALU_WE,
    input  logic [1:0]        iALU_ADDR,
    input  logic [DATA_W-1:0] iALU_DATA,
    input  logic              iLD_ISSUE,
    input  logic [1:0]        iLD_ADDR,
    output logic              oISSUE_READY,
    input  logic              iLD_VALID,
    input  logic [DATA_W-1:0] iLD_DATA,
    output logic              oLD_READY,
    input  logic [1:0]        iRD_SEL,
    output logic              oSTALL,
    output logic [DATA_W-1:0] oREGS [0:NREGS-1],
    output logic [NREGS-1:0]  oPENDING,
    output logic              oWAW_ERR
);

    import bpf_regs_pkg::*;

    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];
    logic                waw_q;
    logic                waw_d;

    logic                fifo_full;
    logic                fifo_empty;
    regaddr_t            head_tag;
    logic [LD_DEPTH-1:0] entry_valid;
    regaddr_t            entry_tag [LD_DEPTH];

    logic                issue_accept;
    logic                ld_accept;
    logic                alu_commit;
    logic [NREGS-1:0]    pending;

    ld_tag_fifo #(
        .DEPTH       (LD_DEPTH)
    ) u_tag_fifo (
        .clk         (iCLK),
        .rst_n       (inRST),
        .push        (iLD_ISSUE),
        .push_tag    (iLD_ADDR),
        .pop         (iLD_VALID),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_tag    (head_tag),
        .entry_valid (entry_valid),
        .entry_tag   (entry_tag)
    );

    // A register is pending while any live FIFO slot names it; duplicates keep it set.
    always_comb begin
        pending = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                if (entry_valid[i] && (entry_tag[i] == regaddr_t'(r))) begin
                    pending[r] = 1'b1;
                end
            end
        end
    end

    // Handshake acceptance and the WAW guard on ALU writes.
    always_comb begin
        issue_accept = iLD_ISSUE && !fifo_full;
        ld_accept    = iLD_VALID && !fifo_empty;
        alu_commit   = iALU_WE && !pending[iALU_ADDR];
        waw_d        = iALU_WE && pending[iALU_ADDR];
    end

    // Register-array next state; the load target is always pending, so it can
    // never coincide with a committed ALU write.
    always_comb begin
        regs_d = regs_q;
        if (alu_commit) begin
            regs_d[iALU_ADDR] = iALU_DATA;
        end
        if (ld_accept) begin
            regs_d[head_tag] = iLD_DATA;
        end
    end

    // Register array and dropped-write flag, cleared asynchronously on reset.
    always_ff @(posedge iCLK or negedge inRST) begin
        if (!inRST) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            waw_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            waw_q  <= waw_d;
        end
    end

    // Output drive; iRD_SEL to oSTALL is the only combinational input path.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            oREGS[r] = regs_q[r];
        end
        oPENDING     = pending;
        oSTALL       = pending[iRD_SEL];
        oWAW_ERR     = waw_q;
        oISSUE_READY = !fifo_full;
        oLD_READY    = !fifo_empty;
    end

    // issue_accept documents the push condition the FIFO applies internally.
    logic unused_ok;
    always_comb begin
        unused_ok = issue_accept;
    end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: ALU writes, load issue/return, WAW drops,
// full-FIFO blocking, empty returns and asynchronous reset mid-operation.
module tb_regfile_sb;

    logic       iCLK;
    logic       inRST;
    logic       iALU_WE;
    logic [1:0] iALU_ADDR;
    logic [7:0] iALU_DATA;
    logic       iLD_ISSUE;
    logic [1:0] iLD_ADDR;
    logic       oISSUE_READY;
    logic       iLD_VALID;
    logic [7:0] iLD_DATA;
    logic       oLD_READY;
    logic [1:0] iRD_SEL;
    logic       oSTALL;
    logic [7:0] oREGS [0:3];
    logic [3:0] oPENDING;
    logic       oWAW_ERR;

    int errors;
    int checks;

    regfile_sb dut (
        .iCLK         (iCLK),
        .inRST        (inRST),
        .iALU_WE      (iALU_WE),
        .iALU_ADDR    (iALU_ADDR),
        .iALU_DATA    (iALU_DATA),
        .iLD_ISSUE    (iLD_ISSUE),
        .iLD_ADDR     (iLD_ADDR),
        .oISSUE_READY (oISSUE_READY),
        .iLD_VALID    (iLD_VALID),
        .iLD_DATA     (iLD_DATA),
        .oLD_READY    (oLD_READY),
        .iRD_SEL      (iRD_SEL),
        .oSTALL       (oSTALL),
        .oREGS        (oREGS),
        .oPENDING     (oPENDING),
        .oWAW_ERR     (oWAW_ERR)
    );

    // 10 ns clock
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // Drive every input for the coming cycle
    task automatic applyStimulus(input logic alu_we, input logic [1:0] alu_addr,
                                 input logic [7:0] alu_data, input logic ld_issue,
                                 input logic [1:0] ld_addr, input logic ld_valid,
                                 input logic [7:0] ld_data, input logic [1:0] rd_sel);
        iALU_WE   = alu_we;
        iALU_ADDR = alu_addr;
        iALU_DATA = alu_data;
        iLD_ISSUE = ld_issue;
        iLD_ADDR  = ld_addr;
        iLD_VALID = ld_valid;
        iLD_DATA  = ld_data;
        iRD_SEL   = rd_sel;
    endtask

    // Advance one rising edge and settle 1 ns past it
    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        inRST  = 1'b0;
        idle();
        #12;

        // Reset state
        checkOutput("rst_r0", oREGS[0], 8'h00);
        checkOutput("rst_r3", oREGS[3], 8'h00);
        checkOutput("rst_pending", oPENDING, 4'b0000);
        checkOutput("rst_stall", oSTALL, 1'b0);
        checkOutput("rst_waw", oWAW_ERR, 1'b0);
        checkOutput("rst_issue_ready", oISSUE_READY, 1'b1);
        checkOutput("rst_ld_ready", oLD_READY, 1'b0);

        step();
        inRST = 1'b1;

        // ALU write A5 -> r2
        applyStimulus(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0);
        step();
        idle();
        checkOutput("alu_r2", oREGS[2], 8'hA5);
        checkOutput("alu_r0", oREGS[0], 8'h00);
        checkOutput("alu_pending", oPENDING, 4'b0000);

        // Load to r1 issued, then returned
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 8'h00, 2'd1);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 2'd1);
        #1;
        checkOutput("ld1_pending", oPENDING, 4'b0010);
        checkOutput("ld1_stall", oSTALL, 1'b1);
        checkOutput("ld1_ld_ready", oLD_READY, 1'b1);
        iRD_SEL = 2'd2;
        #1;
        checkOutput("ld1_stall_other", oSTALL, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'h3C, 2'd1);
        step();
        idle();
        checkOutput("ld1_ret_r1", oREGS[1], 8'h3C);
        checkOutput("ld1_ret_pending", oPENDING, 4'b0000);
        checkOutput("ld1_ret_stall", oSTALL, 1'b0);

        // Two loads to r3 fill the FIFO
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 2'd3);
        step();
        step();
        idle();
        checkOutput("full_issue_ready", oISSUE_READY, 1'b0);
        checkOutput("full_pending", oPENDING, 4'b1000);
        // Return first while an issue to r1 is attempted against a full FIFO
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h11, 2'd3);
        step();
        idle();
        checkOutput("r3_first_r3", oREGS[3], 8'h11);
        checkOutput("r3_first_pending", oPENDING, 4'b1000);
        checkOutput("r3_first_issue_ready", oISSUE_READY, 1'b1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'h22, 2'd3);
        step();
        idle();
        checkOutput("r3_second_r3", oREGS[3], 8'h22);
        checkOutput("r3_second_pending", oPENDING, 4'b0000);
        checkOutput("r3_second_ld_ready", oLD_READY, 1'b0);

        // WAW: pending r0, ALU write FF dropped
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 2'd0);
        step();
        applyStimulus(1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0);
        step();
        idle();
        checkOutput("waw_pulse", oWAW_ERR, 1'b1);
        checkOutput("waw_r0_kept", oREGS[0], 8'h00);
        step();
        checkOutput("waw_pulse_end", oWAW_ERR, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'h44, 2'd0);
        step();
        idle();
        checkOutput("waw_ret_r0", oREGS[0], 8'h44);

        // ALU write to r2 alongside return to pending r1
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 8'h00, 2'd0);
        step();
        applyStimulus(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 1'b1, 8'h77, 2'd0);
        step();
        idle();
        checkOutput("dual_r2", oREGS[2], 8'h5A);
        checkOutput("dual_r1", oREGS[1], 8'h77);
        checkOutput("dual_waw", oWAW_ERR, 1'b0);

        // Return with FIFO empty is ignored
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'h99, 2'd0);
        step();
        idle();
        checkOutput("empty_ret_r0", oREGS[0], 8'h44);
        checkOutput("empty_ret_r1", oREGS[1], 8'h77);
        checkOutput("empty_ret_pending", oPENDING, 4'b0000);

        // ALU write and issue to r0 in the same cycle: write commits
        applyStimulus(1'b1, 2'd0, 8'h12, 1'b1, 2'd0, 1'b0, 8'h00, 2'd0);
        step();
        idle();
        checkOutput("same_cyc_r0", oREGS[0], 8'h12);
        checkOutput("same_cyc_pending", oPENDING, 4'b0001);
        checkOutput("same_cyc_waw", oWAW_ERR, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 8'h00, 2'd0);
        step();
        idle();
        checkOutput("two_out_pending", oPENDING, 4'b0101);

        // Asynchronous reset mid-cycle with two loads outstanding
        #3;
        inRST = 1'b0;
        #1;
        checkOutput("midrst_r0", oREGS[0], 8'h00);
        checkOutput("midrst_r2", oREGS[2], 8'h00);
        checkOutput("midrst_pending", oPENDING, 4'b0000);
        checkOutput("midrst_ld_ready", oLD_READY, 1'b0);
        checkOutput("midrst_issue_ready", oISSUE_READY, 1'b1);
        step();
        inRST = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'hEE, 2'd0);
        step();
        idle();
        checkOutput("post_rst_r0", oREGS[0], 8'h00);
        checkOutput("post_rst_r2", oREGS[2], 8'h00);
        checkOutput("post_rst_pending", oPENDING, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
# regfile_sb

Four-entry, 8-bit register file with a load scoreboard. It sits directly upstream of the 4:1 register-select mux and drives that mux's register-array input. It accepts single-cycle ALU writebacks and out-of-band memory-load returns over a valid/ready handshake. It tracks in-flight load destinations in a 2-entry tag FIFO so the issue stage can stall on a pending source register.

## Interface
Parameters:
- DATA_W, 8, register width
- NREGS, 4, register count (fixed to match the 4:1 select mux)
- LD_DEPTH, 2, maximum outstanding loads (tag FIFO depth)

Ports:
- iCLK  in  1  sole clock, rising edge
- inRST  in  1  reset, asynchronous assert, active-low
- iALU_WE  in  1  ALU writeback strobe
- iALU_ADDR  in  2  ALU destination register
- iALU_DATA  in  8  ALU result
- iLD_ISSUE  in  1  load issued; push destination tag
- iLD_ADDR  in  2  load destination register
- oISSUE_READY  out  1  tag FIFO not full
- iLD_VALID  in  1  load data returning
- iLD_DATA  in  8  load data
- oLD_READY  out  1  tag FIFO not empty
- iRD_SEL  in  2  register the downstream mux will select
- oSTALL  out  1  selected register has a load in flight
- oREGS  out  8 x [0:3]  register contents, to the mux
- oPENDING  out  4  per-register in-flight flag
- oWAW_ERR  out  1  one-cycle pulse: ALU write dropped

## Operation
- Reset (inRST=0, asynchronous) forces the following, held until the first edge after release:
  - all registers = 8'h00
  - tag FIFO empty
  - oPENDING = 4'b0000, oSTALL = 0, oWAW_ERR = 0
  - oISSUE_READY = 1, oLD_READY = 0
- Issue: the FIFO pushes iLD_ADDR when iLD_ISSUE && oISSUE_READY. iLD_ISSUE while full is ignored; the issue stage must not do this.
- Return: accepted when iLD_VALID && oLD_READY.
  - Pops the oldest tag and writes iLD_DATA to that register.
  - iLD_VALID while empty is ignored (no write, no pop).
- oPENDING[r] = OR over valid FIFO entries of (tag == r). It is combinational from registered FIFO state. Two loads to the same register keep the bit set until both retire.
- oSTALL = oPENDING[iRD_SEL], combinational.
- ALU write:
  - Commits iALU_DATA to iALU_ADDR when iALU_WE && !oPENDING[iALU_ADDR].
  - To a pending register it is dropped, and oWAW_ERR is 1 on the next cycle for one cycle.
- Simultaneous events:
  - ALU write and load return to different registers in the same cycle: both commit.
  - Same register is impossible, because that register is pending, so the ALU write is dropped.
  - Issue and return in the same cycle: pop and push both occur. This is legal when full, but oISSUE_READY is !full only, so a full FIFO blocks the issue that cycle.
  - ALU write in the same cycle as an issue to that register: the ALU write commits, because pending is not yet set.
- Reset mid-operation drops all outstanding tags. Returns arriving after reset see oLD_READY=0 and are discarded.

## Timing
- ALU write: visible on oREGS one cycle after the strobe edge.
- Load return: data on oREGS and the pending bit cleared on the same edge, so they are visible together one cycle after acceptance.
- Issue: oPENDING/oSTALL rise one cycle after the issue edge.
- oISSUE_READY, oLD_READY: derived from the registered FIFO count. No combinational path from iLD_* to the ready signals.
- oSTALL: the only combinational path is iRD_SEL to oSTALL.

## Structure
- Shared package bpf_regs_pkg:
  - DATA_W, NREGS, ADDR_W=2
  - typedef reg_t (logic [7:0])
  - typedef regaddr_t (logic [1:0])
  - The select mux imports the same package.
- Sub-module ld_tag_fifo:
  - LD_DEPTH-entry FIFO of regaddr_t with push/pop, full/empty.
  - Exposes entry valid bits and tags for the pending OR-reduction.
- Top-level holds the register array, write-enable/priority logic, oWAW_ERR flop, and stall decode.

## Test plan
- Reset, then ALU writes 8'hA5 to r2 -> oREGS[2]=8'hA5 the next cycle; others 00; oPENDING=0.
- Issue load to r1 -> oPENDING=4'b0010 next cycle. With iRD_SEL=1, oSTALL=1. Return 8'h3C -> oREGS[1]=8'h3C and oPENDING=0 on the same edge.
- Issue loads to r3 then r3 -> oISSUE_READY=0. After the first return, oPENDING[3] stays 1. After the second, it clears; oREGS[3] equals the second data.
- Pending r0, ALU write 8'hFF to r0 -> write dropped, oWAW_ERR pulses 1 cycle, oREGS[0] unchanged.
- Same cycle: ALU write to r2 plus return to pending r1 -> both commit. Then iLD_VALID with FIFO empty -> no register change.
- Two loads outstanding, assert inRST mid-cycle -> immediate clear of oREGS/oPENDING; oLD_READY=0; later returns are ignored.
